// File: rtl/parity_pkg.sv
// Shared encodings for the parity framing datapath: FSM states and parity modes.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a bit index covering 0..data_w-1; never zero so DATA_W=1 still has a register.
  function automatic int idx_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// One-bit XOR accumulator: load seeds it (parity mode), enable folds in one data bit.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= init;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Serialises a parallel word LSB-first and appends an even/odd parity bit, with backpressure.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// DATA  | presenting data bit shreg[0]; advances on ser_ready
// PAR   | presenting the parity bit with ser_last; frame completes on ser_ready
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_sel,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_last,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              acc;
  logic              accept;
  logic              take_bit;
  logic              take_par;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    take_bit  = 1'b0;
    take_par  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        ser_valid = 1'b1;
        ser_out   = shreg[0];
        if (ser_ready) begin
          take_bit = 1'b1;
          if (idx == IDX_LAST) state_nxt = PAR;
        end
      end
      PAR: begin
        ser_valid = 1'b1;
        ser_out   = acc;
        ser_last  = 1'b1;
        if (ser_ready) begin
          take_par  = 1'b1;
          state_nxt = IDLE;
        end
      end
      // The unused encoding presents nothing and falls back to IDLE.
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= in_data;
        idx   <= '0;
      end else if (take_bit) begin
        shreg <= shreg >> 1;
        idx   <= idx + 1'b1;
      end
      if (take_par) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  parity_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .init   (odd_sel),
    .en     (take_bit),
    .bit_in (shreg[0]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: an 8-bit/16-bit-count instance and a 3-bit/2-bit-count instance.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DATA_W=8, CNT_W=16
  logic        a_in_valid = 1'b0, a_in_ready, a_odd_sel = 1'b0;
  logic [7:0]  a_in_data = '0;
  logic        a_ser_valid, a_ser_ready = 1'b0, a_ser_out, a_ser_last, a_busy;
  logic [15:0] a_frame_cnt;
  int          a_exp_cnt = 0;

  // Instance B: DATA_W=3, CNT_W=2
  logic        b_in_valid = 1'b0, b_in_ready, b_odd_sel = 1'b0;
  logic [2:0]  b_in_data = '0;
  logic        b_ser_valid, b_ser_ready = 1'b0, b_ser_out, b_ser_last, b_busy;
  logic [1:0]  b_frame_cnt;

  parity_frame_ctrl #(.DATA_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .odd_sel(a_odd_sel), .ser_valid(a_ser_valid),
    .ser_ready(a_ser_ready), .ser_out(a_ser_out), .ser_last(a_ser_last),
    .busy(a_busy), .frame_cnt(a_frame_cnt)
  );

  parity_frame_ctrl #(.DATA_W(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .odd_sel(b_odd_sel), .ser_valid(b_ser_valid),
    .ser_ready(b_ser_ready), .ser_out(b_ser_out), .ser_last(b_ser_last),
    .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  // Expected k-th frame bit: data bits LSB-first, then parity so that ones-count matches the mode.
  function automatic logic ref_bit(input logic [7:0] w, input logic odd, input int k, input int dw);
    int ones;
    if (k < dw) return w[k];
    ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(w[i]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_ser_valid !== 1'b0 || a_ser_out !== 1'b0 ||
        a_ser_last !== 1'b0 || a_busy !== 1'b0 || a_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_a: rdy=%b val=%b out=%b last=%b busy=%b cnt=%0d, want 1 0 0 0 0 0",
               a_in_ready, a_ser_valid, a_ser_out, a_ser_last, a_busy, a_frame_cnt);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_ser_valid !== 1'b0 || b_busy !== 1'b0 || b_frame_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_b: rdy=%b val=%b busy=%b cnt=%0d, want 1 0 0 0",
               b_in_ready, b_ser_valid, b_busy, b_frame_cnt);
    end
  endtask

  // mode 0: ser_ready always high; 1: random backpressure; 2: 3-cycle stall on bit 2
  task automatic run_frame_a(input logic [7:0] w, input logic odd, input int mode);
    int   k, cyc, stall;
    logic rdy;
    cyc = 0;
    while (!a_in_ready && cyc < 50) begin step(); cyc++; end
    if (!a_in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b, want 1", a_in_ready);
      return;
    end
    a_in_valid = 1'b1; a_in_data = w; a_odd_sel = odd;
    step();
    a_in_valid = 1'b0;
    a_in_data  = 8'($urandom);
    a_odd_sel  = 1'($urandom);
    k = 0; cyc = 1; stall = 0;
    checks++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_accept: busy=%b in_ready=%b, want 1 0", a_busy, a_in_ready);
    end
    while (k <= 8 && cyc < 200) begin
      rdy = 1'b1;
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (mode == 2 && k == 2 && stall < 3) begin rdy = 1'b0; stall++; end
      a_ser_ready = rdy;
      checks++;
      if (a_ser_valid !== 1'b1 || a_ser_out !== ref_bit(w, odd, k, 8) || a_ser_last !== 1'(k == 8)) begin
        errors++;
        $display("FAIL frame_bit w=%h odd=%b k=%0d: valid=%b out=%b last=%b, want 1 %b %b",
                 w, odd, k, a_ser_valid, a_ser_out, a_ser_last, ref_bit(w, odd, k, 8), 1'(k == 8));
      end
      if (rdy) k++;
      step();
      cyc++;
    end
    a_ser_ready = 1'b0;
    if (k <= 8) begin
      checks++; errors++;
      $display("FAIL frame_timeout: bits taken %0d, want 9", k);
      return;
    end
    a_exp_cnt = (a_exp_cnt + 1) % 65536;
    checks++;
    if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_ser_valid !== 1'b0 || a_frame_cnt !== 16'(a_exp_cnt)) begin
      errors++;
      $display("FAIL frame_end: rdy=%b busy=%b val=%b cnt=%0d, want 1 0 0 %0d",
               a_in_ready, a_busy, a_ser_valid, a_frame_cnt, a_exp_cnt);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != 10) begin
        errors++;
        $display("FAIL turnaround: in_ready after %0d cycles, want 10", cyc);
      end
    end
  endtask

  task automatic test_a5_even();
    run_frame_a(8'hA5, 1'b0, 0);
  endtask

  task automatic test_a5_odd();
    run_frame_a(8'hA5, 1'b1, 0);
  endtask

  task automatic test_stall();
    run_frame_a(8'h07, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      run_frame_a(8'($urandom), 1'($urandom), (n % 3 == 0) ? 0 : 1);
  endtask

  task automatic test_reset_mid_frame();
    a_in_valid = 1'b1; a_in_data = 8'hFF; a_odd_sel = 1'b0; a_ser_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (a_ser_valid !== 1'b1 || a_ser_out !== 1'b1 || a_ser_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_bit4: valid=%b out=%b last=%b, want 1 1 0", a_ser_valid, a_ser_out, a_ser_last);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_ser_ready = 1'b0;
    checks++;
    if (a_ser_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_frame: val=%b busy=%b rdy=%b, want 0 0 1", a_ser_valid, a_busy, a_in_ready);
    end
    a_exp_cnt = 0;
    checks++;
    if (a_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_cnt: cnt=%0d, want 0", a_frame_cnt);
    end
  endtask

  // Eight consecutive 3-bit words, even mode, in_valid held high throughout.
  task automatic test_back_to_back();
    logic par_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   cyc;
    b_in_valid = 1'b1; b_odd_sel = 1'b0; b_ser_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      cyc = 0;
      while (!b_in_ready && cyc < 20) begin step(); cyc++; end
      checks++;
      if (!b_in_ready || (w > 0 && cyc != 0)) begin
        errors++;
        $display("FAIL b2b_ready w=%0d: in_ready=%b after %0d waits, want 1 after 0", w, b_in_ready, cyc);
      end
      b_in_data = 3'(w);
      step();
      b_in_data = 3'($urandom);
      b_odd_sel = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (b_ser_valid !== 1'b1 ||
            b_ser_out !== ((k < 3) ? ref_bit(8'(w), 1'b0, k, 3) : par_tab[w]) ||
            b_ser_last !== 1'(k == 3)) begin
          errors++;
          $display("FAIL b2b_bit w=%0d k=%0d: valid=%b out=%b last=%b", w, k, b_ser_valid, b_ser_out, b_ser_last);
        end
        step();
      end
      b_odd_sel = 1'b0;
      checks++;
      if (b_frame_cnt !== 2'((w + 1) % 4)) begin
        errors++;
        $display("FAIL b2b_cnt w=%0d: cnt=%0d, want %0d", w, b_frame_cnt, (w + 1) % 4);
      end
    end
    b_in_valid = 1'b0;
    b_ser_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a5_even();
    test_a5_odd();
    test_stall();
    test_random();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
